// File: rtl/k12a_addr_bus_arbiter.sv
// Address-bus arbiter for the K12A: round-robin grants of the shared address bus,
// a dead turnaround gap between owners and an optional per-tenure hold limit.
module k12a_addr_bus_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int TURNAROUND = 1,
  parameter int MAX_HOLD   = 8,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               cpu_clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] release_req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [NUM_REQ-1:0] load_n,
  output logic [IW-1:0]      owner,
  output logic               busy,
  output logic               timeout
);

  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam int TW = (TURNAROUND > 0) ? $clog2(TURNAROUND + 1) : 1;

  typedef enum logic [1:0] {IDLE, TURN, GRANT} state_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      pend_q, pend_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [HW-1:0]      hold_q, hold_d;
  logic [TW-1:0]      tcnt_q, tcnt_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               timeout_q, timeout_d;
  logic [IW-1:0]      next_ptr, pick_idle, pick_exit, grant_idx;
  logic               leave, forced, start, grant_now;

  // First set request found scanning upward from base, wrapping mod NUM_REQ.
  function automatic logic [IW-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                            input logic [IW-1:0] base);
    logic [IW-1:0] pick;
    logic          found;
    pick  = base;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      int idx;
      idx = (int'(base) + i) % NUM_REQ;
      if (!found && r[IW'(idx)]) begin
        pick  = IW'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign next_ptr  = IW'((int'(owner_q) + 1) % NUM_REQ);
  assign pick_idle = rr_pick(req, ptr_q);
  assign pick_exit = rr_pick(req, next_ptr);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    pend_d    = pend_q;
    owner_d   = owner_q;
    hold_d    = hold_q;
    tcnt_d    = tcnt_q;
    timeout_d = 1'b0;
    start     = 1'b0;
    grant_now = 1'b0;
    grant_idx = '0;
    leave     = release_req[owner_q] | ~req[owner_q];
    forced    = !leave && (MAX_HOLD != 0) && (int'(hold_q) == MAX_HOLD);

    case (state_q)
      IDLE: begin
        if (|req) begin
          pend_d = pick_idle;
          start  = 1'b1;
        end
      end
      TURN: begin
        if (!req[pend_q]) begin
          state_d = IDLE;
        end else if (int'(tcnt_q) + 1 >= TURNAROUND) begin
          grant_now = 1'b1;
          grant_idx = pend_q;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      GRANT: begin
        // A release in the same cycle as the hold limit wins, so no timeout pulse.
        if (leave || forced) begin
          timeout_d = forced;
          ptr_d     = next_ptr;
          if (|req) begin
            pend_d = pick_exit;
            start  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (hold_q != {HW{1'b1}}) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      tcnt_d = '0;
      if (TURNAROUND == 0) begin
        grant_now = 1'b1;
        grant_idx = pend_d;
      end else begin
        state_d = TURN;
      end
    end

    if (grant_now) begin
      state_d = GRANT;
      owner_d = grant_idx;
      hold_d  = HW'(1);
    end

    gnt_d = '0;
    if (state_d == GRANT) gnt_d[owner_d] = 1'b1;
  end

  always_ff @(posedge cpu_clock) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      pend_q    <= '0;
      owner_q   <= '0;
      hold_q    <= '0;
      tcnt_q    <= '0;
      gnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      pend_q    <= pend_d;
      owner_q   <= owner_d;
      hold_q    <= hold_d;
      tcnt_q    <= tcnt_d;
      gnt_q     <= gnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt     = gnt_q;
  assign load_n  = ~gnt_q;
  assign owner   = owner_q;
  assign busy    = (state_q != IDLE);
  assign timeout = timeout_q;

endmodule

// File: tb/tb_k12a_addr_bus_arbiter.sv
// Bench for k12a_addr_bus_arbiter: directed scenarios plus randomized traffic
// compared against a tenure-level reference model.
module tb_k12a_addr_bus_arbiter;

  localparam int N    = 4;
  localparam int MAXH = 8;
  localparam int TA0  = 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req0 = '0, rel0 = '0, req2 = '0, rel2 = '0, req3 = '0, rel3 = '0;
  logic [3:0] gnt0, load_n0, gnt2, load_n2, gnt3, load_n3;
  logic [1:0] owner0, owner2, owner3;
  logic       busy0, busy2, busy3, timeout0, timeout2, timeout3;

  int total = 0;
  int bad   = 0;

  // Reference model state: phase 0 idle, 1 dead gap, 2 owned.
  int m_phase, m_left, m_held, m_ptr, m_pend, m_owner;
  bit m_timeout;

  always #5 clk = ~clk;

  k12a_addr_bus_arbiter #(.NUM_REQ(N), .TURNAROUND(TA0), .MAX_HOLD(MAXH)) u0 (
    .cpu_clock(clk), .reset(reset), .req(req0), .release_req(rel0),
    .gnt(gnt0), .load_n(load_n0), .owner(owner0), .busy(busy0), .timeout(timeout0));

  k12a_addr_bus_arbiter #(.NUM_REQ(N), .TURNAROUND(2), .MAX_HOLD(MAXH)) u2 (
    .cpu_clock(clk), .reset(reset), .req(req2), .release_req(rel2),
    .gnt(gnt2), .load_n(load_n2), .owner(owner2), .busy(busy2), .timeout(timeout2));

  k12a_addr_bus_arbiter #(.NUM_REQ(N), .TURNAROUND(0), .MAX_HOLD(MAXH)) u3 (
    .cpu_clock(clk), .reset(reset), .req(req3), .release_req(rel3),
    .gnt(gnt3), .load_n(load_n3), .owner(owner3), .busy(busy3), .timeout(timeout3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0 = '0; rel0 = '0; req2 = '0; rel2 = '0; req3 = '0; rel3 = '0;
    tick();
    reset = 1'b0;
  endtask

  function automatic int pick_next(input logic [3:0] r, input int from);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (from + k) % N;
      if (r[i]) return i;
    end
    return from;
  endfunction

  task automatic model_begin_tenure();
    if (TA0 == 0) begin
      m_phase = 2; m_owner = m_pend; m_held = 1;
    end else begin
      m_phase = 1; m_left = TA0;
    end
  endtask

  task automatic model_step(input logic rst, input logic [3:0] r, input logic [3:0] rl);
    bit voluntary;
    if (rst) begin
      m_phase = 0; m_ptr = 0; m_pend = 0; m_owner = 0; m_held = 0; m_left = 0;
      m_timeout = 0;
      return;
    end
    m_timeout = 0;
    case (m_phase)
      0: if (r != 0) begin
        m_pend = pick_next(r, m_ptr);
        model_begin_tenure();
      end
      1: if (!r[m_pend]) m_phase = 0;
         else begin
           m_left--;
           if (m_left == 0) begin m_phase = 2; m_owner = m_pend; m_held = 1; end
         end
      default: begin
        voluntary = rl[m_owner] || !r[m_owner];
        if (voluntary || m_held == MAXH) begin
          m_timeout = !voluntary;
          m_ptr = (m_owner + 1) % N;
          if (r != 0) begin
            m_pend = pick_next(r, m_ptr);
            model_begin_tenure();
          end else m_phase = 0;
        end else m_held++;
      end
    endcase
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req0 = 4'b1111;
    for (int c = 0; c < 2; c++) begin
      tick();
      total++;
      if (load_n0 !== 4'b1111 || gnt0 !== 4'b0000 || busy0 !== 1'b0 ||
          owner0 !== 2'd0 || timeout0 !== 1'b0) begin
        bad++;
        $display("[TB] FAIL reset c%0d: load_n=%b gnt=%b busy=%b owner=%0d timeout=%b, want 1111 0000 0 0 0",
                 c, load_n0, gnt0, busy0, owner0, timeout0);
      end
    end
    req0 = '0;
    reset = 1'b0;
  endtask

  task automatic test_single_request();
    do_reset();
    req0 = 4'b0001;
    tick();
    total++;
    if (busy0 !== 1'b1 || load_n0 !== 4'b1111) begin
      bad++;
      $display("[TB] FAIL single_turn: busy=%b load_n=%b, want 1 1111", busy0, load_n0);
    end
    tick();
    total++;
    if (gnt0 !== 4'b0001 || load_n0 !== 4'b1110 || owner0 !== 2'd0) begin
      bad++;
      $display("[TB] FAIL single_grant: gnt=%b load_n=%b owner=%0d, want 0001 1110 0", gnt0, load_n0, owner0);
    end
    tick(); tick(); tick();
    total++;
    if (gnt0 !== 4'b0001) begin
      bad++;
      $display("[TB] FAIL single_hold: gnt=%b, want 0001", gnt0);
    end
    req0 = '0;
    rel0 = 4'b0001;
    tick();
    rel0 = '0;
    total++;
    if (load_n0 !== 4'b1111 || busy0 !== 1'b0 || gnt0 !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL single_release: load_n=%b busy=%b gnt=%b, want 1111 0 0000", load_n0, busy0, gnt0);
    end
  endtask

  task automatic test_round_robin();
    int order[5] = '{0, 1, 2, 3, 0};
    logic [3:0] want;
    do_reset();
    req0 = 4'b1111;
    tick();
    total++;
    if (load_n0 !== 4'b1111 || busy0 !== 1'b1) begin
      bad++;
      $display("[TB] FAIL rr_first_gap: load_n=%b busy=%b, want 1111 1", load_n0, busy0);
    end
    for (int k = 0; k < 5; k++) begin
      want = 4'(1 << order[k]);
      for (int g = 1; g <= 2; g++) begin
        tick();
        total++;
        if (gnt0 !== want || load_n0 !== ~want) begin
          bad++;
          $display("[TB] FAIL rr_grant k%0d g%0d: gnt=%b load_n=%b, want gnt %b", k, g, gnt0, load_n0, want);
        end
      end
      rel0 = want;
      tick();
      rel0 = '0;
      total++;
      if (load_n0 !== 4'b1111 || busy0 !== 1'b1) begin
        bad++;
        $display("[TB] FAIL rr_gap k%0d: load_n=%b busy=%b, want 1111 1", k, load_n0, busy0);
      end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    req0 = 4'b0100;
    tick();
    for (int c = 1; c <= MAXH; c++) begin
      tick();
      total++;
      if (gnt0 !== 4'b0100 || timeout0 !== 1'b0) begin
        bad++;
        $display("[TB] FAIL to_hold c%0d: gnt=%b timeout=%b, want 0100 0", c, gnt0, timeout0);
      end
    end
    tick();
    total++;
    if (timeout0 !== 1'b1 || load_n0 !== 4'b1111 || busy0 !== 1'b1) begin
      bad++;
      $display("[TB] FAIL to_pulse: timeout=%b load_n=%b busy=%b, want 1 1111 1", timeout0, load_n0, busy0);
    end
    tick();
    total++;
    if (gnt0 !== 4'b0100 || timeout0 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL to_regrant: gnt=%b timeout=%b, want 0100 0", gnt0, timeout0);
    end

    do_reset();
    req0 = 4'b0100;
    tick(); tick();
    req0 = 4'b0110;
    for (int c = 2; c <= MAXH; c++) tick();
    total++;
    if (gnt0 !== 4'b0100) begin
      bad++;
      $display("[TB] FAIL to2_hold: gnt=%b, want 0100", gnt0);
    end
    tick();
    total++;
    if (timeout0 !== 1'b1 || load_n0 !== 4'b1111) begin
      bad++;
      $display("[TB] FAIL to2_pulse: timeout=%b load_n=%b, want 1 1111", timeout0, load_n0);
    end
    tick();
    total++;
    if (gnt0 !== 4'b0010 || owner0 !== 2'd1) begin
      bad++;
      $display("[TB] FAIL to2_next: gnt=%b owner=%0d, want 0010 1", gnt0, owner0);
    end
  endtask

  task automatic test_release_at_limit();
    do_reset();
    req0 = 4'b0100;
    tick();
    for (int c = 1; c <= MAXH; c++) tick();
    rel0 = 4'b0100;
    tick();
    rel0 = '0;
    total++;
    if (timeout0 !== 1'b0 || load_n0 !== 4'b1111) begin
      bad++;
      $display("[TB] FAIL limit_release: timeout=%b load_n=%b, want 0 1111", timeout0, load_n0);
    end
  endtask

  task automatic test_ignored_release();
    do_reset();
    req0 = 4'b0100;
    tick(); tick();
    rel0 = 4'b1001;
    tick();
    rel0 = '0;
    total++;
    if (gnt0 !== 4'b0100 || owner0 !== 2'd2) begin
      bad++;
      $display("[TB] FAIL foreign_release: gnt=%b owner=%0d, want 0100 2", gnt0, owner0);
    end
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req0 = '0;
    total++;
    if (load_n0 !== 4'b1111 || busy0 !== 1'b0 || gnt0 !== 4'b0000 || owner0 !== 2'd0) begin
      bad++;
      $display("[TB] FAIL mid_grant_reset: load_n=%b busy=%b gnt=%b owner=%0d, want 1111 0 0000 0",
               load_n0, busy0, gnt0, owner0);
    end
  endtask

  task automatic test_turnaround_variants();
    do_reset();
    req2 = 4'b1000;
    tick();
    tick();
    total++;
    if (busy2 !== 1'b1 || load_n2 !== 4'b1111) begin
      bad++;
      $display("[TB] FAIL ta2_second_gap: busy=%b load_n=%b, want 1 1111", busy2, load_n2);
    end
    req2 = '0;
    tick();
    total++;
    if (busy2 !== 1'b0 || gnt2 !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL ta2_abandon: busy=%b gnt=%b, want 0 0000", busy2, gnt2);
    end
    req2 = 4'b1000;
    tick(); tick(); tick();
    total++;
    if (gnt2 !== 4'b1000 || load_n2 !== 4'b0111) begin
      bad++;
      $display("[TB] FAIL ta2_grant: gnt=%b load_n=%b, want 1000 0111", gnt2, load_n2);
    end
    req2 = '0;

    req3 = 4'b0010;
    tick();
    total++;
    if (gnt3 !== 4'b0010 || load_n3 !== 4'b1101 || owner3 !== 2'd1) begin
      bad++;
      $display("[TB] FAIL ta0_grant: gnt=%b load_n=%b owner=%0d, want 0010 1101 1", gnt3, load_n3, owner3);
    end
    req3 = 4'b0011;
    rel3 = 4'b0010;
    tick();
    rel3 = '0;
    total++;
    if (gnt3 !== 4'b0001 || owner3 !== 2'd0) begin
      bad++;
      $display("[TB] FAIL ta0_handover: gnt=%b owner=%0d, want 0001 0", gnt3, owner3);
    end
    req3 = '0;
  endtask

  task automatic test_random();
    logic [3:0] exp_gnt;
    do_reset();
    model_step(1'b1, '0, '0);
    for (int cyc = 0; cyc < 800; cyc++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 9) == 0) req0[b] = ~req0[b];
      rel0  = 4'($urandom & $urandom & $urandom & $urandom);
      reset = ($urandom_range(0, 149) == 0);
      tick();
      model_step(reset, req0, rel0);
      exp_gnt = (m_phase == 2) ? 4'(1 << m_owner) : 4'b0000;
      total++;
      if (gnt0 !== exp_gnt || load_n0 !== ~exp_gnt || owner0 !== 2'(m_owner) ||
          busy0 !== (m_phase != 0) || timeout0 !== m_timeout) begin
        bad++;
        $display("[TB] FAIL random cyc%0d: gnt=%b owner=%0d busy=%b timeout=%b, want %b %0d %b %b",
                 cyc, gnt0, owner0, busy0, timeout0, exp_gnt, m_owner, (m_phase != 0), m_timeout);
      end
      total++;
      if ($countones(~load_n0) > 1) begin
        bad++;
        $display("[TB] FAIL random_onehot cyc%0d: load_n=%b, want at most one low", cyc, load_n0);
      end
    end
    reset = 1'b0;
    req0 = '0;
    rel0 = '0;
  endtask

  initial begin
    test_reset();
    test_single_request();
    test_round_robin();
    test_timeout();
    test_release_at_limit();
    test_ignored_release();
    test_turnaround_variants();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
